// File: rtl/pc_flag_unit.sv
// Program counter, ALU flag/overflow registers and start/halt sequencing with a
// saturating run-cycle counter. Every output is registered.
module pc_flag_unit #(
    parameter int PC_W  = 10,
    parameter int CNT_W = 16
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             START,
    input  logic [PC_W-1:0]  START_ADDR,
    input  logic             STALL,
    input  logic             HALT,
    input  logic             FLAG_IN_ALU,
    input  logic             OVF_IN_ALU,
    input  logic             BRANCH_EN,
    input  logic [PC_W-1:0]  BRANCH_TARGET,
    input  logic             FLAG_WE,
    input  logic             OVF_WE,
    output logic [PC_W-1:0]  PC,
    output logic             FLAG_Q,
    output logic             OVF_Q,
    output logic             RUNNING,
    output logic             DONE,
    output logic [CNT_W-1:0] CYCLE_CNT
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        HALTED = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t state;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state     <= IDLE;
            PC        <= '0;
            FLAG_Q    <= 1'b0;
            OVF_Q     <= 1'b0;
            RUNNING   <= 1'b0;
            DONE      <= 1'b0;
            CYCLE_CNT <= '0;
        end else begin
            case (state)
                IDLE, HALTED: begin
                    if (START) begin
                        state     <= RUN;
                        PC        <= START_ADDR;
                        FLAG_Q    <= 1'b0;
                        OVF_Q     <= 1'b0;
                        CYCLE_CNT <= '0;
                        RUNNING   <= 1'b1;
                        DONE      <= 1'b0;
                    end
                end
                RUN: begin
                    // Counts stalled cycles and the halting cycle too.
                    if (CYCLE_CNT != CNT_MAX) begin
                        CYCLE_CNT <= CYCLE_CNT + 1'b1;
                    end
                    if (!STALL) begin
                        if (FLAG_WE) FLAG_Q <= FLAG_IN_ALU;
                        if (OVF_WE)  OVF_Q  <= OVF_IN_ALU;
                        if (HALT) begin
                            state   <= HALTED;
                            RUNNING <= 1'b0;
                            DONE    <= 1'b1;
                        end else if (BRANCH_EN) begin
                            PC <= BRANCH_TARGET;
                        end else begin
                            PC <= PC + 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    RUNNING <= 1'b0;
                    DONE    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_flag_unit.sv
// Directed plus randomized bench for pc_flag_unit against a behavioural model;
// a second instance with a 4-bit counter covers counter saturation.
module tb_pc_flag_unit;

    localparam int PC_W = 10;

    logic            CLK;
    logic            RESET_N;
    logic            start;
    logic [PC_W-1:0] start_addr;
    logic            stall;
    logic            halt;
    logic            flag_in;
    logic            ovf_in;
    logic            br;
    logic [PC_W-1:0] tgt;
    logic            flag_we;
    logic            ovf_we;

    logic [PC_W-1:0] pc;
    logic            flag_q, ovf_q, running, done;
    logic [15:0]     cnt;

    logic [PC_W-1:0] pc_s;
    logic            flag_q_s, ovf_q_s, running_s, done_s;
    logic [3:0]      cnt_s;

    pc_flag_unit #(.PC_W(PC_W), .CNT_W(16)) u_dut (
        .CLK(CLK), .RESET_N(RESET_N), .START(start), .START_ADDR(start_addr),
        .STALL(stall), .HALT(halt), .FLAG_IN_ALU(flag_in), .OVF_IN_ALU(ovf_in),
        .BRANCH_EN(br), .BRANCH_TARGET(tgt), .FLAG_WE(flag_we), .OVF_WE(ovf_we),
        .PC(pc), .FLAG_Q(flag_q), .OVF_Q(ovf_q), .RUNNING(running), .DONE(done),
        .CYCLE_CNT(cnt)
    );

    pc_flag_unit #(.PC_W(PC_W), .CNT_W(4)) u_dut_c4 (
        .CLK(CLK), .RESET_N(RESET_N), .START(start), .START_ADDR(start_addr),
        .STALL(stall), .HALT(halt), .FLAG_IN_ALU(flag_in), .OVF_IN_ALU(ovf_in),
        .BRANCH_EN(br), .BRANCH_TARGET(tgt), .FLAG_WE(flag_we), .OVF_WE(ovf_we),
        .PC(pc_s), .FLAG_Q(flag_q_s), .OVF_Q(ovf_q_s), .RUNNING(running_s), .DONE(done_s),
        .CYCLE_CNT(cnt_s)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Behavioural model: mode 0 = idle, 1 = run, 2 = halted.
    int m_mode, m_pc, m_flag, m_ovf, m_cnt, m_cnt4;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 0; m_flag = 0; m_ovf = 0; m_cnt = 0; m_cnt4 = 0;
    endtask

    task automatic model_step();
        if (m_mode == 1) begin
            m_cnt  = (m_cnt  < 65535) ? m_cnt  + 1 : 65535;
            m_cnt4 = (m_cnt4 < 15)    ? m_cnt4 + 1 : 15;
            if (!stall) begin
                if (flag_we) m_flag = int'(flag_in);
                if (ovf_we)  m_ovf  = int'(ovf_in);
                if (halt)    m_mode = 2;
                else if (br) m_pc   = int'(tgt);
                else         m_pc   = (m_pc + 1) % (1 << PC_W);
            end
        end else if (start) begin
            m_mode = 1; m_pc = int'(start_addr);
            m_flag = 0; m_ovf = 0; m_cnt = 0; m_cnt4 = 0;
        end
    endtask

    task automatic compare_all();
        check("pc",      32'(pc),       32'(m_pc));
        check("flag_q",  32'(flag_q),   32'(m_flag));
        check("ovf_q",   32'(ovf_q),    32'(m_ovf));
        check("running", 32'(running),  32'(m_mode == 1));
        check("done",    32'(done),     32'(m_mode == 2));
        check("cnt",     32'(cnt),      32'(m_cnt));
        check("cnt4",    32'(cnt_s),    32'(m_cnt4));
        check("pc_c4",   32'(pc_s),     32'(m_pc));
    endtask

    task automatic clear_inputs();
        start = 0; start_addr = '0; stall = 0; halt = 0; flag_in = 0; ovf_in = 0;
        br = 0; tgt = '0; flag_we = 0; ovf_we = 0;
    endtask

    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
        compare_all();
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        clear_inputs();
        RESET_N = 1'b0;
        model_reset();
        #2;
        compare_all();
        check("rst_pc", 32'(pc), 32'h0);
        #1 RESET_N = 1'b1;

        // Idle ignores everything except START
        halt = 1; br = 1; tgt = 10'h155; flag_we = 1; flag_in = 1; ovf_we = 1; ovf_in = 1;
        cycles(2);
        check("idle_run", 32'(running), 32'h0);

        clear_inputs();
        start = 1; start_addr = 10'h040;
        cycle();
        check("start_pc", 32'(pc), 32'h040);
        check("start_running", 32'(running), 32'h1);
        clear_inputs();
        cycles(3);
        check("seq_pc", 32'(pc), 32'h043);
        check("seq_cnt", 32'(cnt), 32'd3);

        br = 1; tgt = 10'h050;
        cycle();
        tgt = 10'h120;
        cycle();
        check("branch_pc", 32'(pc), 32'h120);
        stall = 1; br = 1; tgt = 10'h1AA;
        cycles(2);
        check("stall_pc", 32'(pc), 32'h120);
        check("stall_cnt", 32'(cnt), 32'd7);

        clear_inputs();
        flag_we = 1; flag_in = 1; ovf_we = 0; ovf_in = 1;
        cycle();
        check("flag_wr", 32'(flag_q), 32'h1);
        check("ovf_nowr", 32'(ovf_q), 32'h0);
        stall = 1; flag_in = 0; ovf_we = 1;
        cycle();
        check("stall_flag", 32'(flag_q), 32'h1);
        check("stall_ovf", 32'(ovf_q), 32'h0);

        clear_inputs();
        br = 1; tgt = 10'h3FF;
        cycle();
        clear_inputs();
        cycle();
        check("wrap_pc", 32'(pc), 32'h000);
        check("wrap_running", 32'(running), 32'h1);

        br = 1; tgt = 10'h010;
        cycle();
        halt = 1; br = 1; tgt = 10'h200; flag_we = 1; flag_in = 0; ovf_we = 1; ovf_in = 1;
        cycle();
        check("halt_pc", 32'(pc), 32'h010);
        check("halt_done", 32'(done), 32'h1);
        check("halt_running", 32'(running), 32'h0);
        check("halt_ovf", 32'(ovf_q), 32'h1);
        clear_inputs();
        halt = 1; br = 1; tgt = 10'h2AA;
        cycles(2);
        check("halted_pc", 32'(pc), 32'h010);

        clear_inputs();
        start = 1; start_addr = 10'h000;
        cycle();
        check("restart_run", 32'(running), 32'h1);
        check("restart_done", 32'(done), 32'h0);
        check("restart_cnt", 32'(cnt), 32'h0);
        check("restart_ovf", 32'(ovf_q), 32'h0);
        clear_inputs();
        flag_we = 1; flag_in = 1;
        cycles(3);

        // Asynchronous reset between edges
        #2 RESET_N = 1'b0;
        model_reset();
        #1;
        compare_all();
        check("async_run", 32'(running), 32'h0);
        #2 RESET_N = 1'b1;

        clear_inputs();
        start = 1; start_addr = 10'h100;
        cycle();
        clear_inputs();
        cycles(20);
        check("sat_cnt4", 32'(cnt_s), 32'd15);
        check("cnt20", 32'(cnt), 32'd20);

        for (int i = 0; i < 400; i++) begin
            start      = ($urandom_range(0, 15) == 0);
            start_addr = PC_W'($urandom);
            stall      = ($urandom_range(0, 3) == 0);
            halt       = ($urandom_range(0, 19) == 0);
            br         = ($urandom_range(0, 3) == 0);
            tgt        = PC_W'($urandom);
            flag_in    = 1'($urandom);
            ovf_in     = 1'($urandom);
            flag_we    = 1'($urandom);
            ovf_we     = 1'($urandom);
            cycle();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
